// File: rtl/word_serializer_tx_if.sv
// Handshake and serial-link bundle for word_serializer_tx.
`timescale 1ns/1ps
interface word_serializer_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_start;
  logic             frame_done;
  logic             busy;

  // Upstream word source / serial-link observer side
  modport master (
    output in_data, in_valid,
    input  in_ready, ser_out, ser_valid, frame_start, frame_done, busy
  );

  // Serializer side
  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_out, ser_valid, frame_start, frame_done, busy
  );
endinterface

// File: rtl/word_serializer_tx.sv
// Parallel-to-serial transmitter: captures a word on valid/ready and shifts
// it out one bit per CLKS_PER_BIT clocks, with frame start/done pulses.
`timescale 1ns/1ps
module word_serializer_tx #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter bit          MSB_FIRST    = 1'b1
) (
  input logic                 clk,
  input logic                 reset,
  word_serializer_tx_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shadow;
  logic [IDX_W-1:0]   r_bit_idx;
  logic [DIV_W-1:0]   r_div;
  logic               r_ser_out;
  logic               r_ser_valid;
  logic               r_frame_start;
  logic               r_frame_done;

  logic               w_div_wrap;
  logic               w_last;
  logic               w_ready;
  logic               w_accept;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [DIV_W-1:0]   w_div_nxt;

  // Selects frame bit k of a word according to the configured bit order
  function automatic logic f_pick(input logic [WIDTH-1:0] word, input logic [IDX_W-1:0] k);
    if (MSB_FIRST) begin
      return word[IDX_W'(WIDTH - 1) - k];
    end
    return word[k];
  endfunction

  // Frame position decode; the last frame cycle reopens the input for a gapless chain
  assign w_div_wrap = (r_div == DIV_W'(CLKS_PER_BIT - 1));
  assign w_last     = (r_state == SHIFT) && (r_bit_idx == IDX_W'(WIDTH - 1)) && w_div_wrap;
  assign w_ready    = (r_state == IDLE) || w_last;
  assign w_accept   = bus.in_valid && w_ready;
  assign w_idx_nxt  = r_bit_idx + IDX_W'(1);
  assign w_div_nxt  = r_div + DIV_W'(1);

  // Transmit FSM with registered serial outputs and frame pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_shadow      <= '0;
      r_bit_idx     <= '0;
      r_div         <= '0;
      r_ser_out     <= 1'b0;
      r_ser_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      if (w_accept) begin
        // New frame: from IDLE or chained directly off the previous last cycle
        r_state       <= SHIFT;
        r_shadow      <= bus.in_data;
        r_bit_idx     <= '0;
        r_div         <= '0;
        r_ser_out     <= f_pick(bus.in_data, IDX_W'(0));
        r_ser_valid   <= 1'b1;
        r_frame_start <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
          end
          SHIFT: begin
            if (w_last) begin
              r_state     <= IDLE;
              r_bit_idx   <= '0;
              r_div       <= '0;
              r_ser_out   <= 1'b0;
              r_ser_valid <= 1'b0;
            end else if (w_div_wrap) begin
              r_bit_idx    <= w_idx_nxt;
              r_div        <= '0;
              r_ser_out    <= f_pick(r_shadow, w_idx_nxt);
              r_frame_done <= (w_idx_nxt == IDX_W'(WIDTH - 1)) && (CLKS_PER_BIT == 1);
            end else begin
              r_div        <= w_div_nxt;
              r_frame_done <= (r_bit_idx == IDX_W'(WIDTH - 1)) &&
                              (w_div_nxt == DIV_W'(CLKS_PER_BIT - 1));
            end
          end
          default: begin
            r_state     <= IDLE;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output mapping; busy mirrors ser_valid
  assign bus.in_ready    = w_ready;
  assign bus.ser_out     = r_ser_out;
  assign bus.ser_valid   = r_ser_valid;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_done  = r_frame_done;
  assign bus.busy        = r_ser_valid;

endmodule
